vga_line_fetch_sched: RTL

//  Line-fetch scheduler feeding the VGA timing controller from a framebuffer in memory.

---
 rtl/vga_line_fetch_sched.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_line_fetch_sched.sv
// Line-fetch scheduler: bursts framebuffer lines from memory into two ping-pong
// line buffers and serves registered 4:4:4 pixels to the VGA timing controller.
module vga_line_fetch_sched #(
  parameter int MAX_PIX   = 640,
  parameter int BURST_LEN = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en_i,
  input  logic [31:0] fb_base_i,
  input  logic [10:0] line_pix_i,
  input  logic [9:0]  lines_i,
  input  logic        frame_start_i,
  input  logic        pix_req_i,
  output logic [11:0] pix_data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        underrun_o
);

  localparam int WORDS = MAX_PIX / 2;
  localparam int IW    = $clog2(WORDS);
  localparam int WL    = $clog2(WORDS + 1);
  localparam int BW    = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT} fstate_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bstate_t;

  fstate_t        state, state_nx;
  bstate_t        buf_st [2];
  logic [31:0]    addr;
  logic [WL-1:0]  words_left;
  logic [9:0]     fetch_line;
  logic           tgt;
  logic [IW-1:0]  widx;
  logic [BW-1:0]  blen, beat_cnt, burst_len_c;
  logic           drop, restart_pend;
  logic           disp_sel, line_ur;
  logic [10:0]    pix_cnt;

  // Only the two 12-bit pixel fields of each beat are kept.
  logic [23:0]    buf0 [WORDS];
  logic [23:0]    buf1 [WORDS];
  logic [23:0]    rd_word;
  logic [IW-1:0]  rd_idx;
  logic [11:0]    pix_sel;
  logic           unused_rdata;

  logic abort_now, burst_end, discard, go_restart, line_done;
  logic restart, next_line, wr_en, disp_ok, pix_take, line_end;

  assign unused_rdata = ^{mem_rdata_i[31:28], mem_rdata_i[15:12]};

  assign burst_len_c = (words_left < WL'(BURST_LEN)) ? BW'(words_left) : BW'(BURST_LEN);
  assign mem_req_o   = (state == REQ);
  assign mem_addr_o  = (state == REQ) ? addr : 32'd0;
  assign mem_len_o   = (state == REQ) ? 8'(burst_len_c) : 8'd0;

  assign abort_now  = frame_start_i || !en_i;
  assign burst_end  = (state == DATA) && mem_rvalid_i && (beat_cnt == blen - BW'(1));
  // A burst already granted is always counted to completion; discard marks its beats as dead.
  assign discard    = drop || abort_now;
  assign go_restart = en_i && (restart_pend || frame_start_i);
  assign line_done  = (words_left == WL'(blen));
  assign restart    = (en_i && frame_start_i && (state == IDLE || state == WAIT)) ||
                      (burst_end && discard && go_restart);
  assign next_line  = (state == WAIT) && en_i && !frame_start_i &&
                      (fetch_line != lines_i) && (buf_st[tgt] == B_EMPTY);
  assign wr_en      = (state == DATA) && mem_rvalid_i && !discard;

  assign rd_idx   = pix_cnt[IW:1];
  assign rd_word  = disp_sel ? buf1[rd_idx] : buf0[rd_idx];
  assign pix_sel  = pix_cnt[0] ? rd_word[23:12] : rd_word[11:0];
  assign disp_ok  = (buf_st[disp_sel] == B_FULL) && !line_ur;
  assign pix_take = en_i && !frame_start_i && pix_req_i;
  assign line_end = (pix_cnt == line_pix_i - 11'd1);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (restart) state_nx = REQ;
      REQ:  if (mem_gnt_i) state_nx = DATA;
      DATA: if (burst_end) begin
        if (discard)         state_nx = go_restart ? REQ : IDLE;
        else if (!line_done) state_nx = REQ;
        else                 state_nx = WAIT;
      end
      WAIT: begin
        if (!en_i)                     state_nx = IDLE;
        else if (restart || next_line) state_nx = REQ;
        else if (fetch_line == lines_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (tgt) buf1[widx] <= {mem_rdata_i[27:16], mem_rdata_i[11:0]};
      else     buf0[widx] <= {mem_rdata_i[27:16], mem_rdata_i[11:0]};
    end
  end

  // Update order matters: fetch, then display frees, then abort, then restart.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_st[0]    <= B_EMPTY;
      buf_st[1]    <= B_EMPTY;
      addr         <= 32'd0;
      words_left   <= '0;
      fetch_line   <= 10'd0;
      tgt          <= 1'b0;
      widx         <= '0;
      blen         <= '0;
      beat_cnt     <= '0;
      drop         <= 1'b0;
      restart_pend <= 1'b0;
      disp_sel     <= 1'b0;
      line_ur      <= 1'b0;
      pix_cnt      <= 11'd0;
      pix_data_o   <= 12'h000;
      underrun_o   <= 1'b0;
    end else begin
      if (state == REQ && mem_gnt_i) begin
        blen     <= burst_len_c;
        beat_cnt <= '0;
      end
      if ((state == REQ || state == DATA) && abort_now) begin
        drop         <= 1'b1;
        restart_pend <= en_i;
      end
      if (state == DATA && mem_rvalid_i) begin
        beat_cnt <= beat_cnt + BW'(1);
        if (!discard) widx <= widx + IW'(1);
      end
      if (burst_end) begin
        drop         <= 1'b0;
        restart_pend <= 1'b0;
        if (!discard) begin
          addr       <= addr + (32'(blen) << 2);
          words_left <= words_left - WL'(blen);
          if (line_done) begin
            buf_st[tgt] <= B_FULL;
            fetch_line  <= fetch_line + 10'd1;
            tgt         <= ~tgt;
          end
        end
      end
      if (next_line) begin
        words_left  <= WL'(line_pix_i[10:1]);
        widx        <= '0;
        buf_st[tgt] <= B_FILLING;
      end

      if (pix_take) begin
        pix_data_o <= disp_ok ? pix_sel : 12'h000;
        if (!disp_ok) begin
          underrun_o <= 1'b1;
          line_ur    <= 1'b1;
        end
        if (line_end) begin
          pix_cnt          <= 11'd0;
          line_ur          <= 1'b0;
          disp_sel         <= ~disp_sel;
          buf_st[disp_sel] <= B_EMPTY;
        end else begin
          pix_cnt <= pix_cnt + 11'd1;
        end
      end

      if (abort_now) begin
        buf_st[0] <= B_EMPTY;
        buf_st[1] <= B_EMPTY;
        disp_sel  <= 1'b0;
        pix_cnt   <= 11'd0;
        line_ur   <= 1'b0;
      end
      if (!en_i) begin
        underrun_o <= 1'b0;
        pix_data_o <= 12'h000;
      end
      if (restart) begin
        addr         <= fb_base_i;
        words_left   <= WL'(line_pix_i[10:1]);
        fetch_line   <= 10'd0;
        tgt          <= 1'b0;
        widx         <= '0;
        drop         <= 1'b0;
        restart_pend <= 1'b0;
        buf_st[0]    <= B_FILLING;
      end
    end
  end

endmodule
